// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg
//   Shared definitions for the ADC sequencer: register map addresses,
//   CTRL/STATUS bit positions and the sequencer state encoding.
package adc_seq_pkg;

   // Register map (word addresses on the 2-bit register bus)
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_NUM    = 2'd1;
   localparam logic [1:0] ADDR_DATA   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // CTRL write fields
   localparam int CTRL_START    = 0;
   localparam int CTRL_STOP     = 1;
   localparam int CTRL_CONT     = 2;
   localparam int CTRL_CLEAR    = 3;
   localparam int CTRL_MASK_LSB = 8;

   // STATUS fields
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_FULL      = 3;
   localparam int STAT_OVF       = 4;
   localparam int STAT_LEVEL_LSB = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo
//   Single-clock synchronous FIFO with show-ahead read data, occupancy
//   level, full/empty flags and a one-cycle clear.
//   Ports:
//     clock, reset   : clock, asynchronous active-high reset
//     clear          : empty the FIFO (wins over push/pop in the same cycle)
//     push, wdata    : write request and entry
//     pop            : read request (ignored when empty)
//     rdata          : entry at the head of the FIFO
//     level          : number of stored entries
//     full, empty    : occupancy flags
//   A push while full is accepted only when a pop happens in the same cycle.
module adc_sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && (!full || do_pop) && !clear;
   assign rdata   = mem[rd_ptr];

   // Storage is data only: no reset needed
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/adc_seq_fifo.sv
// adc_seq_fifo
//   Multi-channel ADC conversion sequencer with a sample FIFO behind a
//   small register interface.
//   Ports:
//     clock, reset        : single clock, asynchronous active-high reset
//     address, read,      : register bus (CTRL=0, NUM=1, DATA=2, STATUS=3),
//     write, writedata,     read data registered one cycle after read
//     readdata
//     conv_go, conv_ch    : one-cycle start-conversion pulse and its channel
//     conv_done, conv_data: converter result strobe and value
//     busy                : sequencer in ISSUE or WAIT
//     irq                 : done | overflow (level)
module adc_seq_fifo
   import adc_seq_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int NUM_CH     = 8,
   parameter int FIFO_DEPTH = 256
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [1:0]                address,
   input  logic                      read,
   input  logic                      write,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic                      conv_go,
   output logic [$clog2(NUM_CH)-1:0] conv_ch,
   input  logic                      conv_done,
   input  logic [DATA_W-1:0]         conv_data,
   output logic                      busy,
   output logic                      irq
);

   localparam int CHW = $clog2(NUM_CH);
   localparam int EW  = CHW + DATA_W;
   localparam int LW  = $clog2(FIFO_DEPTH) + 1;

   seq_state_t        state;
   seq_state_t        state_next;
   logic [NUM_CH-1:0] mask;
   logic              cont;
   logic [15:0]       num;
   logic [15:0]       count;
   logic [15:0]       count_inc;
   logic              done;
   logic              overflow;
   logic              stop_pend;

   logic              wr_ctrl;
   logic              wr_status;
   logic              start_req;
   logic              stop_req;
   logic              clear_req;
   logic [NUM_CH-1:0] wr_mask;
   logic              do_start;
   logic              accept;
   logic              finish;

   logic              pop_req;
   logic              ovf_event;
   logic [EW-1:0]     fifo_head;
   logic [LW-1:0]     fifo_level;
   logic              fifo_full;
   logic              fifo_empty;
   logic [31:0]       rd_mux;
   logic              unused_wd;

   function automatic logic [CHW-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      logic [CHW-1:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) r = CHW'(i);
      end
      return r;
   endfunction

   // Next enabled channel strictly above c, wrapping to the lowest enabled one
   function automatic logic [CHW-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                              input logic [CHW-1:0]    c);
      logic [CHW-1:0] r;
      logic           found;
      r     = lowest_ch(m);
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found && m[i] && (i > int'(c))) begin
            r     = CHW'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] fmt_data(input logic valid, input logic [EW-1:0] e);
      logic [31:0] w;
      w = '0;
      if (valid) begin
         w = {1'b1, 11'b0, 4'(e[EW-1 -: CHW]), 16'(e[DATA_W-1:0])};
      end
      return w;
   endfunction

   assign wr_ctrl   = write && (address == ADDR_CTRL);
   assign wr_status = write && (address == ADDR_STATUS);
   assign start_req = wr_ctrl && writedata[CTRL_START];
   assign stop_req  = wr_ctrl && writedata[CTRL_STOP];
   assign clear_req = wr_ctrl && writedata[CTRL_CLEAR];
   assign wr_mask   = writedata[CTRL_MASK_LSB +: NUM_CH];
   assign count_inc = count + 16'd1;
   assign unused_wd = ^writedata;

   assign busy    = (state == ST_ISSUE) || (state == ST_WAIT);
   assign irq     = done || overflow;
   assign conv_go = (state == ST_ISSUE);

   // A sample is lost only when the FIFO stays full through this cycle
   assign pop_req   = read && (address == ADDR_DATA) && !fifo_empty;
   assign ovf_event = accept && fifo_full && !pop_req && !clear_req;

   always_comb begin
      state_next = state;
      do_start   = 1'b0;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start_req && (wr_mask != '0)) begin
               do_start = 1'b1;
               if (!writedata[CTRL_CONT] && (num == 16'd0)) begin
                  state_next = ST_DONE;
                  finish     = 1'b1;
               end else begin
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            state_next = stop_req ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (conv_done) begin
               accept = 1'b1;
               if (stop_req || stop_pend) begin
                  state_next = ST_IDLE;
               end else if (!cont && (count_inc == num)) begin
                  state_next = ST_DONE;
                  finish     = 1'b1;
               end else begin
                  state_next = ST_ISSUE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_CTRL: begin
            rd_mux[CTRL_CONT]                 = cont;
            rd_mux[CTRL_MASK_LSB +: NUM_CH]   = mask;
         end
         ADDR_NUM: begin
            rd_mux[15:0] = num;
         end
         ADDR_DATA: begin
            rd_mux = fmt_data(!fifo_empty, fifo_head);
         end
         default: begin
            rd_mux[STAT_BUSY]              = busy;
            rd_mux[STAT_DONE]              = done;
            rd_mux[STAT_EMPTY]             = fifo_empty;
            rd_mux[STAT_FULL]              = fifo_full;
            rd_mux[STAT_OVF]               = overflow;
            rd_mux[STAT_LEVEL_LSB +: 16]   = 16'(fifo_level);
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         mask      <= '0;
         cont      <= 1'b0;
         num       <= '0;
         count     <= '0;
         conv_ch   <= '0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         stop_pend <= 1'b0;
         readdata  <= '0;
      end else begin
         state <= state_next;

         // Configuration is frozen while a run is in progress
         if (wr_ctrl && !busy) begin
            mask <= wr_mask;
            cont <= writedata[CTRL_CONT];
         end
         if (write && (address == ADDR_NUM)) begin
            num <= writedata[15:0];
         end

         if (do_start) begin
            count   <= '0;
            conv_ch <= lowest_ch(wr_mask);
         end else if (accept) begin
            count   <= count_inc;
            conv_ch <= next_ch(mask, conv_ch);
         end

         // A stop seen in WAIT is held until the outstanding result arrives
         stop_pend <= (state_next == ST_WAIT) && (stop_pend || stop_req);

         if (finish) begin
            done <= 1'b1;
         end else if (do_start || (wr_status && writedata[STAT_DONE])) begin
            done <= 1'b0;
         end

         if (ovf_event) begin
            overflow <= 1'b1;
         end else if (wr_status && writedata[STAT_OVF]) begin
            overflow <= 1'b0;
         end

         if (read) begin
            readdata <= rd_mux;
         end
      end
   end

   adc_sample_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (clear_req),
      .push  (accept),
      .pop   (pop_req),
      .wdata ({conv_ch, conv_data}),
      .rdata (fifo_head),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_adc_seq_fifo.sv
module tb_adc_seq_fifo;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        conv_go;
   logic [2:0]  conv_ch;
   logic        conv_done = 1'b0;
   logic [11:0] conv_data = '0;
   logic        busy;
   logic        irq;

   int tests = 0;
   int fails = 0;

   adc_seq_fifo #(
      .DATA_W     (12),
      .NUM_CH     (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .address   (address),
      .read      (read),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .conv_go   (conv_go),
      .conv_ch   (conv_ch),
      .conv_done (conv_done),
      .conv_data (conv_data),
      .busy      (busy),
      .irq       (irq)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clock);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge clock);
      write     = 1'b0;
      writedata = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clock);
      address = a;
      read    = 1'b1;
      @(negedge clock);
      read    = 1'b0;
      d       = readdata;
   endtask

   task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(tag, d, exp);
   endtask

   // Wait (bounded) for the conversion request, then check its channel
   task automatic wait_go(input string tag, input logic [2:0] ch);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (conv_go) found = 1'b1;
         else @(negedge clock);
      end
      check({tag, "_go"}, 32'(found), 32'd1);
      if (found) check({tag, "_ch"}, 32'(conv_ch), 32'(ch));
   endtask

   task automatic reply(input logic [11:0] d);
      @(negedge clock);
      conv_done = 1'b1;
      conv_data = d;
      @(negedge clock);
      conv_done = 1'b0;
      conv_data = '0;
   endtask

   initial begin
      logic [31:0] d;

      // Reset state
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("rst_readdata", readdata, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_go", 32'(conv_go), 32'd0);
      check("rst_ch", 32'(conv_ch), 32'd0);
      read_check("rst_status", 2'd3, 32'h0000_0004);
      read_check("rst_num", 2'd1, 32'h0);

      // Zero mask start is ignored
      bus_write(2'd0, 32'h0000_0001);
      check("zmask_busy", 32'(busy), 32'd0);
      check("zmask_go", 32'(conv_go), 32'd0);

      // Single run, mask 0x05, NUM 4
      bus_write(2'd1, 32'd4);
      read_check("num_rb", 2'd1, 32'd4);
      bus_write(2'd0, 32'h0000_0501);
      check("s1_busy", 32'(busy), 32'd1);
      wait_go("s1_0", 3'd0); reply(12'h100);
      wait_go("s1_1", 3'd2); reply(12'h101);
      wait_go("s1_2", 3'd0); reply(12'h102);
      wait_go("s1_3", 3'd2); reply(12'h103);
      check("s1_irq", 32'(irq), 32'd1);
      check("s1_busy_end", 32'(busy), 32'd0);
      read_check("s1_status", 2'd3, 32'h0004_000A);
      read_check("s1_d0", 2'd2, 32'h8000_0100);
      read_check("s1_d1", 2'd2, 32'h8002_0101);
      read_check("s1_d2", 2'd2, 32'h8000_0102);
      read_check("s1_d3", 2'd2, 32'h8002_0103);
      read_check("s1_status_empty", 2'd3, 32'h0000_0006);

      // DATA read while empty
      bus_read(2'd2, d);
      check("empty_valid", 32'(d[31]), 32'd0);
      read_check("empty_level", 2'd3, 32'h0000_0006);
      bus_write(2'd3, 32'h0000_0002);
      check("s1_irq_clr", 32'(irq), 32'd0);

      // Overflow: NUM 6 into a 4-deep FIFO
      bus_write(2'd1, 32'd6);
      bus_write(2'd0, 32'h0000_0501);
      wait_go("ov_0", 3'd0); reply(12'h200);
      wait_go("ov_1", 3'd2); reply(12'h201);
      wait_go("ov_2", 3'd0); reply(12'h202);
      wait_go("ov_3", 3'd2); reply(12'h203);
      wait_go("ov_4", 3'd0); reply(12'h204);
      wait_go("ov_5", 3'd2); reply(12'h205);
      read_check("ov_status", 2'd3, 32'h0004_001A);
      read_check("ov_d0", 2'd2, 32'h8000_0200);
      read_check("ov_d1", 2'd2, 32'h8002_0201);
      read_check("ov_d2", 2'd2, 32'h8000_0202);
      read_check("ov_d3", 2'd2, 32'h8002_0203);
      bus_write(2'd3, 32'h0000_0012);
      check("ov_irq_clr", 32'(irq), 32'd0);
      read_check("ov_status_clr", 2'd3, 32'h0000_0004);

      // Full FIFO with a DATA read in the same cycle as conv_done
      bus_write(2'd1, 32'd5);
      bus_write(2'd0, 32'h0000_0101);
      wait_go("fp_0", 3'd0); reply(12'h300);
      wait_go("fp_1", 3'd0); reply(12'h301);
      wait_go("fp_2", 3'd0); reply(12'h302);
      wait_go("fp_3", 3'd0); reply(12'h303);
      wait_go("fp_4", 3'd0);
      @(negedge clock);
      conv_done = 1'b1;
      conv_data = 12'h304;
      address   = 2'd2;
      read      = 1'b1;
      @(negedge clock);
      conv_done = 1'b0;
      read      = 1'b0;
      check("fp_pop_data", readdata, 32'h8000_0300);
      read_check("fp_status", 2'd3, 32'h0004_000A);
      read_check("fp_d1", 2'd2, 32'h8000_0301);
      read_check("fp_d2", 2'd2, 32'h8000_0302);
      read_check("fp_d3", 2'd2, 32'h8000_0303);
      read_check("fp_d4", 2'd2, 32'h8000_0304);
      bus_write(2'd3, 32'h0000_0002);

      // Continuous mode on channel 7, stop while waiting for a result
      bus_write(2'd0, 32'h0000_8005);
      wait_go("ct_0", 3'd7); reply(12'h3A1);
      wait_go("ct_1", 3'd7);
      bus_write(2'd0, 32'h0000_0002);
      check("ct_busy_pend", 32'(busy), 32'd1);
      reply(12'h3A2);
      check("ct_busy_end", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      check("ct_no_go", 32'(conv_go), 32'd0);
      check("ct_irq", 32'(irq), 32'd0);
      read_check("ct_status", 2'd3, 32'h0002_0000);
      read_check("ct_d0", 2'd2, 32'h8007_03A1);
      read_check("ct_d1", 2'd2, 32'h8007_03A2);

      // NUM 0 in single mode finishes without converting
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'h0000_0101);
      check("n0_go", 32'(conv_go), 32'd0);
      check("n0_busy", 32'(busy), 32'd0);
      check("n0_irq", 32'(irq), 32'd1);
      read_check("n0_status", 2'd3, 32'h0000_0006);
      bus_write(2'd3, 32'h0000_0002);

      // fifo_clear empties the FIFO
      bus_write(2'd1, 32'd1);
      bus_write(2'd0, 32'h0000_0201);
      wait_go("cl_0", 3'd1); reply(12'h0AB);
      bus_write(2'd0, 32'h0000_0008);
      read_check("cl_status", 2'd3, 32'h0000_0006);
      bus_write(2'd3, 32'h0000_0002);

      // Reset while waiting for a result, then a late conv_done
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'h0000_0101);
      wait_go("rw_0", 3'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rw_readdata", readdata, 32'h0);
      check("rw_busy", 32'(busy), 32'd0);
      check("rw_irq", 32'(irq), 32'd0);
      check("rw_go", 32'(conv_go), 32'd0);
      check("rw_ch", 32'(conv_ch), 32'd0);
      reply(12'h3FF);
      check("rw_busy_after", 32'(busy), 32'd0);
      check("rw_go_after", 32'(conv_go), 32'd0);
      read_check("rw_status", 2'd3, 32'h0000_0004);
      read_check("rw_num", 2'd1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_seq_fifo.md
ADC_SEQ_FIFO -- requirements
Module: adc_seq_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 12, converter sample width in bits.
REQ-002 SHALL have parameter NUM_CH, default 8, channel count (2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 256, sample FIFO entries (power of two).
REQ-004 SHALL have ports: clock in 1, the single clock; reset in 1, asynchronous active-high.
REQ-005 SHALL have ports: address in 2, register select; read in 1, read strobe; write in 1, write strobe; writedata in 32, write data; readdata out 32, read data.
REQ-006 SHALL have ports: conv_go out 1, start-conversion pulse; conv_ch out $clog2(NUM_CH), channel for the conversion; conv_done in 1, result-valid pulse; conv_data in DATA_W, result.
REQ-007 SHALL have ports: busy out 1, sequencer active; irq out 1, level-high when done or overflow.

Function
REQ-008 SHALL decode address 0 as CTRL for write: bit0 start, bit1 stop, bit2 continuous, bit3 fifo_clear, bits[8+NUM_CH-1:8] channel mask.
REQ-009 SHALL decode address 1 as NUM, read/write, bits[15:0] = total samples per run.
REQ-010 SHALL decode address 2 as DATA, read-only, returning {valid, 11'b0, ch zero-extended to 4 bits, data zero-extended to 16 bits}; valid = 0 when the FIFO is empty.
REQ-011 SHALL decode address 3 as STATUS: bit0 busy, bit1 done, bit2 empty, bit3 full, bit4 overflow, bits[31:16] FIFO level; a write of 1 to bit1 or bit4 clears that bit.
REQ-012 SHALL register readdata one cycle after read is asserted (read latency 1).
REQ-013 SHALL pop exactly one FIFO entry per read cycle at address 2 when the FIFO is not empty; a read while empty SHALL NOT change any state.
REQ-014 SHALL implement the sequencer states IDLE, ISSUE, WAIT and DONE.
REQ-015 SHALL leave IDLE or DONE for ISSUE on start with a nonzero mask; on start it SHALL clear done, zero the sample count, and select the lowest enabled channel.
REQ-016 SHALL ignore start when the mask is zero, and ignore start while busy.
REQ-017 SHALL, in ISSUE, assert conv_go for exactly one cycle with conv_ch held stable, then enter WAIT.
REQ-018 SHALL, in WAIT on conv_done, push {conv_ch, conv_data}, increment the count, and advance to the next enabled channel above the current one, wrapping to the lowest.
REQ-019 SHALL, after the push in REQ-018, enter DONE when the count equals NUM in single mode, and otherwise return to ISSUE on the next cycle.
REQ-020 SHALL, in continuous mode, run until stop with no sample limit.
REQ-021 SHALL, on stop, return to IDLE after any outstanding conv_done (or immediately from ISSUE), without setting done.
REQ-022 SHALL treat NUM = 0 in single mode as an immediate transition to DONE with no conversion.
REQ-023 SHALL, when the FIFO is full and a push occurs without a same-cycle pop, drop the sample and set sticky overflow; a simultaneous push and pop when full SHALL be accepted.
REQ-024 SHALL, on fifo_clear, empty the FIFO in one cycle, with clear taking priority over a same-cycle push or pop.
REQ-025 SHALL ignore conv_done outside WAIT.
REQ-026 SHALL drive busy high in ISSUE and WAIT, and drive irq = done | overflow.

Reset
REQ-027 SHALL, on reset, set state IDLE, FIFO empty, mask/NUM/continuous 0, done/overflow 0, conv_go 0, conv_ch 0, readdata 0, busy 0, irq 0.
REQ-028 SHALL, on reset mid-conversion, discard any later conv_done until the next start.

Structure
REQ-029 SHALL place register addresses, CTRL/STATUS bit positions and the state enum in package adc_seq_pkg.
REQ-030 SHALL use one sub-module, adc_sample_fifo: a single-clock synchronous FIFO with level, full, empty and clear.

Verification
REQ-031 SHALL cover: mask 0x05, NUM 4, single mode, start -> samples ch 0, 2, 0, 2 pushed, then done = 1, irq = 1, busy = 0.
REQ-032 SHALL cover: FIFO_DEPTH 4, NUM 6, no reads -> level 4, overflow = 1, first four samples intact on readout.
REQ-033 SHALL cover: continuous mode with mask 0x80, stop during WAIT -> final sample pushed, IDLE, done = 0.
REQ-034 SHALL cover: full FIFO with a DATA read in the same cycle as conv_done -> level unchanged, overflow = 0.
REQ-035 SHALL cover: reset asserted in WAIT, then a conv_done pulse -> no push, state IDLE, all outputs 0.
REQ-036 SHALL cover: DATA read while empty -> readdata valid bit 0, level stays 0.
